mdu_div_fsm: RTL and testbench

//   Iterative radix-2 integer divider for DIV/DIVU in the EXE stage; it is the source of DIVMULTBusy.

---
 rtl/mdu_div_if.sv | 26 ++
 rtl/mdu_div_fsm.sv | 123 ++++++++++++
 tb/tb_mdu_div_fsm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_div_if.sv
// Handshake bundle between the EXE stage / Control and the iterative divider.
// master = pipeline side (drives operands and control), slave = divider.
interface mdu_div_if #(
  parameter int WIDTH = 32
);
  logic             EXE_Start;
  logic             EXE_IsSigned;
  logic [WIDTH-1:0] EXE_Dividend;
  logic [WIDTH-1:0] EXE_Divisor;
  logic             Flush;
  logic             EXE_Wr;
  logic             DIVMULTBusy;
  logic             ResultValid;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;

  modport master (
    output EXE_Start, EXE_IsSigned, EXE_Dividend, EXE_Divisor, Flush, EXE_Wr,
    input  DIVMULTBusy, ResultValid, Quotient, Remainder
  );

  modport slave (
    input  EXE_Start, EXE_IsSigned, EXE_Dividend, EXE_Divisor, Flush, EXE_Wr,
    output DIVMULTBusy, ResultValid, Quotient, Remainder
  );
endinterface

// File: rtl/mdu_div_fsm.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EXE.
// Operands are made positive on start, WIDTH shift/subtract steps follow,
// and the signs are reapplied on the last step so DONE holds final values.
// Busy stalls the pipeline while a divide is starting or in flight.
module mdu_div_fsm #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mdu_div_if.slave     bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;      // partial remainder; MSB stays 0 between steps
  logic [WIDTH-1:0] quo;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             valid_q;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  // operand sign and magnitude; only DIV treats the MSB as a sign
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign a_neg = bus.EXE_IsSigned & bus.EXE_Dividend[WIDTH-1];
  assign b_neg = bus.EXE_IsSigned & bus.EXE_Divisor[WIDTH-1];
  assign abs_a = a_neg ? -bus.EXE_Dividend : bus.EXE_Dividend;
  assign abs_b = b_neg ? -bus.EXE_Divisor  : bus.EXE_Divisor;

  // one restoring step: shift {rem,quo} left, trial-subtract the divisor.
  // Two extra bits on the subtract make the borrow unambiguous.
  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             last_step;

  always_comb begin
    ext     = {rem, quo[WIDTH-1]};
    diff    = ext - {2'b00, dvs};
    borrow  = diff[WIDTH+1];
    rem_nxt = ext[WIDTH:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!borrow) begin
      rem_nxt = diff[WIDTH:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

  assign last_step = (cnt == CW'(WIDTH - 1));

  // control FSM with datapath registers; flush and reset both abandon work
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      valid_q <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
    end else if (bus.Flush) begin
      // HI/LO registers are left untouched; only the state unwinds
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.EXE_Start) begin
            quo   <= abs_a;
            dvs   <= abs_b;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            rem   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            // sign fix-up uses wrap-around negate, so MIN/-1 yields MIN, 0
            q_out   <= q_neg ? -quo_nxt : quo_nxt;
            r_out   <= r_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // EXE_Start is still high for the same instruction; wait for EXE_Wr
          if (bus.EXE_Wr) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Busy must be masked by Flush (Control ranks it higher) and never
  // depends on EXE_Wr, which is itself derived from Busy.
  assign bus.DIVMULTBusy = ~bus.Flush & ~rst &
                           (((state == IDLE) & bus.EXE_Start) | (state == BUSY));
  assign bus.ResultValid = valid_q & ~rst;
  assign bus.Quotient    = q_out;
  assign bus.Remainder   = r_out;
endmodule

// File: tb/tb_mdu_div_fsm.sv
// Directed bench for mdu_div_fsm: timing of Busy, signed/unsigned results,
// flush/reset aborts, DONE hold and back-to-back operation.
module tb_mdu_div_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mdu_div_if #(.WIDTH(32)) bus ();
  mdu_div_fsm #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic wr);
    @(posedge clk); #1;
    bus.EXE_IsSigned = s;
    bus.EXE_Dividend = a;
    bus.EXE_Divisor  = b;
    bus.EXE_Wr       = wr;
    bus.EXE_Start    = 1'b1;
  endtask

  // counts Busy cycles until ResultValid, bounded; returns X results on timeout
  task automatic wait_done(output int nb, output logic [31:0] q, output logic [31:0] r);
    nb = 0; q = 'x; r = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.DIVMULTBusy) nb++;
      if (bus.ResultValid) begin
        q = bus.Quotient;
        r = bus.Remainder;
        break;
      end
    end
  endtask

  task automatic end_div();
    @(posedge clk); #1;
    bus.EXE_Start = 1'b0;
    bus.EXE_Wr    = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.DIVMULTBusy); end
    checks++; if (bus.ResultValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.ResultValid); end
    checks++; if (bus.Quotient !== 32'h0) begin errors++; $display("FAIL rst_q: got %h want 0", bus.Quotient); end
    checks++; if (bus.Remainder !== 32'h0) begin errors++; $display("FAIL rst_r: got %h want 0", bus.Remainder); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.EXE_Start = 1'b0;
  endtask

  task automatic test_basic();
    int nb; logic [31:0] q, r;
    start_div(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done(nb, q, r);
    checks++; if (nb !== 33) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 33", nb); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL basic_q: got %h want %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL basic_r: got %h want %h", r, 32'd2); end
    end_div();
    @(negedge clk);
    checks++; if (bus.ResultValid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b want 0", bus.ResultValid); end
    checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", bus.DIVMULTBusy); end
  endtask

  task automatic test_signed();
    logic        s  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a  [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5, 32'hFFFFFF9C, 32'hFFFFFFFF};
    logic [31:0] b  [6] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFF9, 32'h10};
    logic [31:0] eq [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd14, 32'h0FFFFFFF};
    logic [31:0] er [6] = '{32'hFFFFFFFF, 32'd1, 32'h0, 32'd5, 32'hFFFFFFFE, 32'hF};
    int nb; logic [31:0] q, r;
    for (int i = 0; i < 6; i++) begin
      start_div(s[i], a[i], b[i], 1'b1);
      wait_done(nb, q, r);
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL signed_q[%0d]: got %h want %h", i, q, eq[i]); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL signed_r[%0d]: got %h want %h", i, r, er[i]); end
      end_div();
    end
  endtask

  task automatic test_flush();
    int nb; logic [31:0] q, r;
    // flush at BUSY step 10
    start_div(1'b0, 32'd1000, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    #1 bus.Flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.DIVMULTBusy); end
    @(posedge clk); #1 bus.Flush = 1'b0;
    wait_done(nb, q, r);
    checks++; if (nb !== 33) begin errors++; $display("FAIL flush_restart_cycles: got %0d want 33", nb); end
    checks++; if (q !== 32'd142) begin errors++; $display("FAIL flush_q: got %h want %h", q, 32'd142); end
    checks++; if (r !== 32'd6) begin errors++; $display("FAIL flush_r: got %h want %h", r, 32'd6); end
    end_div();
    // flush coincident with start: no start
    @(posedge clk); #1;
    bus.EXE_IsSigned = 1'b0; bus.EXE_Dividend = 32'd9; bus.EXE_Divisor = 32'd3;
    bus.EXE_Start = 1'b1; bus.Flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", bus.DIVMULTBusy); end
    @(posedge clk); #1 bus.Flush = 1'b0;
    wait_done(nb, q, r);
    checks++; if (nb !== 33) begin errors++; $display("FAIL flush_start_cycles: got %0d want 33", nb); end
    checks++; if (q !== 32'd3 || r !== 32'd0) begin errors++; $display("FAIL flush_start_qr: got %h/%h want 3/0", q, r); end
    end_div();
    // flush while in DONE drops ResultValid, leaves results alone
    start_div(1'b0, 32'd50, 32'd6, 1'b0);
    wait_done(nb, q, r);
    @(posedge clk); #1 bus.Flush = 1'b1;
    @(posedge clk); #1 bus.Flush = 1'b0; bus.EXE_Start = 1'b0; bus.EXE_Wr = 1'b1;
    @(negedge clk);
    checks++; if (bus.ResultValid !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %b want 0", bus.ResultValid); end
    checks++; if (bus.Quotient !== 32'd8) begin errors++; $display("FAIL flush_done_q: got %h want %h", bus.Quotient, 32'd8); end
  endtask

  task automatic test_hold();
    int nb; logic [31:0] q, r;
    start_div(1'b0, 32'd1000, 32'd33, 1'b0);
    wait_done(nb, q, r);
    checks++; if (nb !== 33) begin errors++; $display("FAIL hold_cycles: got %0d want 33", nb); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.ResultValid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.ResultValid); end
      checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL hold_busy[%0d]: got %b want 0", i, bus.DIVMULTBusy); end
      checks++; if (bus.Quotient !== 32'd30 || bus.Remainder !== 32'd10) begin
        errors++; $display("FAIL hold_qr[%0d]: got %h/%h want 1e/a", i, bus.Quotient, bus.Remainder); end
    end
    @(posedge clk); #1 bus.EXE_Wr = 1'b1;
    @(posedge clk); #1 bus.EXE_Start = 1'b0;
    @(negedge clk);
    checks++; if (bus.ResultValid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b want 0", bus.ResultValid); end
    checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL hold_release_busy: got %b want 0", bus.DIVMULTBusy); end
  endtask

  task automatic test_back_to_back();
    int nb; logic [31:0] q, r;
    start_div(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done(nb, q, r);
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL b2b_q0: got %h want %h", q, 32'd14); end
    start_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1);
    wait_done(nb, q, r);
    checks++; if (nb !== 33) begin errors++; $display("FAIL b2b_cycles: got %0d want 33", nb); end
    checks++; if (q !== 32'hFFFFFFF2) begin errors++; $display("FAIL b2b_q1: got %h want fffffff2", q); end
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_r1: got %h want fffffffe", r); end
    end_div();
  endtask

  task automatic test_rst_mid();
    int nb; logic [31:0] q, r;
    start_div(1'b0, 32'd1234, 32'd5, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.DIVMULTBusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.DIVMULTBusy); end
    @(posedge clk); #1 rst = 1'b0; bus.EXE_Start = 1'b0;
    @(negedge clk);
    checks++; if (bus.ResultValid !== 1'b0 || bus.DIVMULTBusy !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got valid=%b busy=%b want 0/0", bus.ResultValid, bus.DIVMULTBusy); end
    checks++; if (bus.Quotient !== 32'h0 || bus.Remainder !== 32'h0) begin
      errors++; $display("FAIL rstmid_qr: got %h/%h want 0/0", bus.Quotient, bus.Remainder); end
    start_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
    wait_done(nb, q, r);
    checks++; if (nb !== 33) begin errors++; $display("FAIL rstmid_cycles: got %0d want 33", nb); end
    checks++; if (q !== 32'hFFFFFFFF || r !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h/%h want ffffffff/0", q, r); end
    end_div();
  endtask

  initial begin
    bus.EXE_Start    = 1'b1;
    bus.EXE_IsSigned = 1'b0;
    bus.EXE_Dividend = 32'd10;
    bus.EXE_Divisor  = 32'd3;
    bus.Flush        = 1'b0;
    bus.EXE_Wr       = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_flush();
    test_hold();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
